// File: rtl/uart_rx_pkg.sv
// Shared 8N1 UART definitions: default line rate, frame constants and receiver states.
package uart_rx_pkg;

    localparam int unsigned DefaultUartBps = 9600;
    localparam int unsigned DefaultClkFreq = 50_000_000;
    localparam int unsigned DataBits       = 8;
    localparam int unsigned BaudCntW       = 16;
    localparam logic        StopLevel      = 1'b1;
    localparam logic        IdleLevel      = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel byte plus status pulses out.
interface uart_rx_if;

    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    modport master (
        output rx,
        input  po_data,
        input  po_flag,
        input  frame_err
    );

    modport slave (
        input  rx,
        output po_data,
        output po_flag,
        output frame_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, samples each bit at mid-bit and emits one-cycle
// po_flag / frame_err pulses per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned UART_BPS = DefaultUartBps,
    parameter int unsigned CLK_FREQ = DefaultClkFreq
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    uart_rx_if.slave  bus
);

    localparam int unsigned         BaudCntMax = CLK_FREQ / UART_BPS;
    localparam logic [BaudCntW-1:0] BaudLast   = BaudCntW'(BaudCntMax - 1);
    localparam logic [BaudCntW-1:0] Half       = BaudCntW'(BaudCntMax / 2);
    localparam logic [2:0]          LastBit    = 3'(DataBits - 1);

    logic                rx_s;
    logic                sample;
    rx_state_e           state_q, state_d;
    logic                armed_q, armed_d;
    logic [1:0]          fill_q, fill_d;
    logic [BaudCntW-1:0] baud_q, baud_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          po_data_q, po_data_d;
    logic                po_flag_q, po_flag_d;
    logic                frame_err_q, frame_err_d;

    sync_2ff #(
        .ResetVal (IdleLevel)
    ) u_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (bus.rx),
        .q_o    (rx_s)
    );

    assign sample = (baud_q == Half);

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b0;
        // The synchroniser holds its reset level for two cycles after release; those
        // stale highs must not arm a start on a line that is really low.
        fill_d      = {fill_q[0], 1'b1};
        baud_d      = (baud_q == BaudLast) ? '0 : baud_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (armed_q && !rx_s) begin
                    state_d = StStart;
                end else begin
                    armed_d = armed_q | (rx_s & fill_q[1]);
                end
            end
            StStart: begin
                if (sample) begin
                    if (!rx_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                // Leave at mid-stop so the next start edge can be caught back-to-back.
                if (sample) begin
                    state_d = StIdle;
                    if (rx_s == StopLevel) begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle || state_d == StIdle) begin
            baud_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            fill_q      <= '0;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            po_data_q   <= '0;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            fill_q      <= fill_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_flag   = po_flag_q;
    assign bus.frame_err = frame_err_q;

endmodule
